// File: rtl/spi_slave_sampler_if.sv
// RX/TX word stream between spi_slave_sampler and the SoC-side logic.
// slave: endpoint side (produces RX words, consumes TX words).
// master: consumer/producer side driving the handshake.
interface spi_slave_sampler_if;
  logic [31:0] rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic [31:0] tx_data_i;
  logic        tx_valid_i;
  logic        tx_ready_o;

  modport slave (
    output rx_data_o, rx_valid_o, tx_ready_o,
    input  rx_ready_i, tx_data_i, tx_valid_i
  );

  modport master (
    input  rx_data_o, rx_valid_o, tx_ready_o,
    output rx_ready_i, tx_data_i, tx_valid_i
  );
endinterface

// File: rtl/spi_slave_sampler.sv
// Oversampling SPI mode-0 slave (MSB first). SPI pins are synchronised into
// HCLK; 32-bit words are deserialised into a valid/ready stream and, in
// standard mode, a TX word stream is serialised onto MISO.
// Optional quad receive is enabled by defining SPI_SLAVE_QUAD_EN.
// SYNC_STAGES must be at least 2.
module spi_slave_sampler #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic HCLK,
  input  logic HRESET,
  input  logic spi_clk,
  input  logic spi_csn,
  input  logic spi_sdi0,
  input  logic spi_sdi1,
  input  logic spi_sdi2,
  input  logic spi_sdi3,
  output logic spi_miso,
  output logic spi_miso_oe,
  input  logic qmode_i,
  spi_slave_sampler_if.slave bus,
  output logic eot_o,
  output logic rx_partial_o,
  output logic rx_overflow_o,
  output logic tx_underrun_o
);

  localparam int unsigned L_CSN = 0;
  localparam int unsigned L_CLK = 1;
  localparam int unsigned L_D0  = 2;
`ifdef SPI_SLAVE_QUAD_EN
  localparam int unsigned NL = 6;
`else
  localparam int unsigned NL = 3;
`endif

  typedef enum logic [1:0] {WAIT_IDLE = 2'd0, IDLE = 2'd1, ACTIVE = 2'd2} state_t;

  state_t state_q, state_d;

  logic [NL-1:0]                  pin;
  logic [SYNC_STAGES-1:0][NL-1:0] sync_q;
  logic [NL-1:0]                  sync_s;
  logic [NL-1:0]                  hist_q;
  logic clk_rise_q, clk_fall_q, csn_rise_q, csn_fall_q;

  logic        qmode;
  logic [3:0]  lanes;
  logic [5:0]  cnt_q;
  logic [31:0] rx_sh_q, rx_next;
  logic [31:0] tx_sh_q, load_word;
  logic [31:0] rx_data_q;
  logic        rx_valid_q, miso_q, eot_q, partial_q, ovf_q, und_q;
  logic        enter, leave, rise_act, fall_act, word_last, word_done, tx_load;

`ifdef SPI_SLAVE_QUAD_EN
  assign pin   = {spi_sdi3, spi_sdi2, spi_sdi1, spi_sdi0, spi_clk, spi_csn};
  assign qmode = qmode_i;
  assign lanes = hist_q[5:2];
`else
  assign pin   = {spi_sdi0, spi_clk, spi_csn};
  assign qmode = 1'b0;
  assign lanes = {3'b000, hist_q[L_D0]};
  logic unused_pins;
  assign unused_pins = ^{qmode_i, spi_sdi1, spi_sdi2, spi_sdi3};
`endif

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain, history flop and registered edge events. Registering
  // the events delays the data lanes by the same amount via hist_q, so the
  // lane value used on an edge is the one sampled with that edge.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sync_q     <= '0;
      hist_q     <= '0;
      clk_rise_q <= 1'b0;
      clk_fall_q <= 1'b0;
      csn_rise_q <= 1'b0;
      csn_fall_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], pin};
      hist_q     <= sync_s;
      clk_rise_q <=  sync_s[L_CLK] & ~hist_q[L_CLK];
      clk_fall_q <= ~sync_s[L_CLK] &  hist_q[L_CLK];
      csn_rise_q <=  sync_s[L_CSN] & ~hist_q[L_CSN];
      csn_fall_q <= ~sync_s[L_CSN] &  hist_q[L_CSN];
    end
  end

  // FSM state register.
  always_ff @(posedge HCLK) begin
    if (HRESET) state_q <= WAIT_IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-cycle actions; a csn event masks any clock edge.
  always_comb begin
    state_d  = state_q;
    enter    = 1'b0;
    leave    = 1'b0;
    rise_act = 1'b0;
    fall_act = 1'b0;
    case (state_q)
      WAIT_IDLE: if (hist_q[L_CSN]) state_d = IDLE;
      IDLE: if (csn_fall_q) begin
        state_d = ACTIVE;
        enter   = 1'b1;
      end
      ACTIVE: if (csn_rise_q) begin
        state_d = IDLE;
        leave   = 1'b1;
      end else if (!csn_fall_q) begin
        rise_act = clk_rise_q;
        fall_act = clk_fall_q;
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  assign word_last = qmode ? (cnt_q == 6'd7) : (cnt_q == 6'd31);
  assign word_done = rise_act & word_last;
  assign rx_next   = qmode ? {rx_sh_q[27:0], lanes} : {rx_sh_q[30:0], lanes[0]};
  assign tx_load   = !qmode && (enter || (fall_act && cnt_q == '0));
  assign load_word = bus.tx_valid_i ? bus.tx_data_i : '0;

  // Bit counter, shift registers, RX output register and status flags.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      cnt_q      <= '0;
      rx_sh_q    <= '0;
      tx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      miso_q     <= 1'b0;
      eot_q      <= 1'b0;
      partial_q  <= 1'b0;
      ovf_q      <= 1'b0;
      und_q      <= 1'b0;
    end else begin
      eot_q     <= leave;
      partial_q <= leave && (cnt_q != '0);

      if (enter || leave)  cnt_q <= '0;
      else if (rise_act)   cnt_q <= word_last ? '0 : cnt_q + 6'd1;

      if (enter)           rx_sh_q <= '0;
      else if (rise_act)   rx_sh_q <= rx_next;

      if (leave) begin
        miso_q  <= 1'b0;
        tx_sh_q <= '0;
      end else if (tx_load) begin
        tx_sh_q <= load_word;
        miso_q  <= load_word[31];
        if (!bus.tx_valid_i) und_q <= 1'b1;
      end else if (fall_act && !qmode) begin
        miso_q  <= tx_sh_q[30];
        tx_sh_q <= {tx_sh_q[30:0], 1'b0};
      end

      if (word_done) begin
        if (!rx_valid_q || bus.rx_ready_i) begin
          rx_data_q  <= rx_next;
          rx_valid_q <= 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end else if (rx_valid_q && bus.rx_ready_i) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign spi_miso       = miso_q;
  assign spi_miso_oe    = (state_q == ACTIVE) && !qmode;
  assign bus.rx_data_o  = rx_data_q;
  assign bus.rx_valid_o = rx_valid_q;
  assign bus.tx_ready_o = tx_load;
  assign eot_o          = eot_q;
  assign rx_partial_o   = partial_q;
  assign rx_overflow_o  = ovf_q;
  assign tx_underrun_o  = und_q;

endmodule

// File: tb/tb_spi_slave_sampler.sv
// Bench for spi_slave_sampler: SPI master model, TX supplier, RX scoreboard.
module tb_spi_slave_sampler;
  localparam int unsigned H = 5;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  logic spi_clk = 1'b0, spi_csn = 1'b1;
  logic spi_sdi0 = 1'b0, spi_sdi1 = 1'b0, spi_sdi2 = 1'b0, spi_sdi3 = 1'b0;
  logic qmode_i = 1'b0;
  logic spi_miso, spi_miso_oe, eot_o, rx_partial_o, rx_overflow_o, tx_underrun_o;

  spi_slave_sampler_if u_if();

  spi_slave_sampler #(.SYNC_STAGES(2)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .spi_clk(spi_clk), .spi_csn(spi_csn),
    .spi_sdi0(spi_sdi0), .spi_sdi1(spi_sdi1), .spi_sdi2(spi_sdi2), .spi_sdi3(spi_sdi3),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .qmode_i(qmode_i), .bus(u_if.slave),
    .eot_o(eot_o), .rx_partial_o(rx_partial_o),
    .rx_overflow_o(rx_overflow_o), .tx_underrun_o(tx_underrun_o)
  );

  always #5 HCLK = ~HCLK;

  int unsigned n_tests = 0, n_fail = 0;
  logic [31:0] exp_rx_q[$], exp_miso_q[$], m_words[$];
  bit rx_hold = 1'b0, model_on = 1'b1, miso_chk = 1'b1, oe_seen = 1'b0;
  bit exp_ovf = 1'b0, exp_und = 1'b0;
  int unsigned eot_cnt = 0, partial_cnt = 0, load_cnt = 0;
  int unsigned exp_eot = 0, exp_partial = 0, exp_loads = 0;
  int unsigned bidx = 0, mcnt = 0;
  logic [31:0] miso_acc = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // RX monitor: drives ready, pops the scoreboard on each transfer.
  initial begin
    bit stall_prev;
    logic [31:0] stall_data;
    stall_prev = 1'b0;
    stall_data = '0;
    u_if.rx_ready_i = 1'b0;
    forever begin
      @(negedge HCLK);
      u_if.rx_ready_i = rx_hold ? 1'b0 : 1'($urandom_range(0, 1));
      if (eot_o) eot_cnt++;
      if (rx_partial_o) partial_cnt++;
      if (spi_miso_oe) oe_seen = 1'b1;
      if (u_if.rx_valid_o && stall_prev) check("rx_stable", u_if.rx_data_o, stall_data);
      if (u_if.rx_valid_o && u_if.rx_ready_i) begin
        if (exp_rx_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rx_unexpected: got %h expected no word", u_if.rx_data_o);
        end else begin
          check("rx_data", u_if.rx_data_o, exp_rx_q.pop_front());
        end
      end
      stall_prev = u_if.rx_valid_o && !u_if.rx_ready_i;
      stall_data = u_if.rx_data_o;
    end
  end

  // TX supplier: records what the endpoint loads, then offers a new word.
  initial begin
    u_if.tx_data_i = 32'hA5A5_0F0F;
    forever begin
      @(negedge HCLK);
      if (u_if.tx_ready_o) begin
        load_cnt++;
        exp_miso_q.push_back(u_if.tx_valid_i ? u_if.tx_data_i : 32'h0);
        @(posedge HCLK);
        #1 u_if.tx_data_i = $urandom;
      end
    end
  end

  task automatic send_bits(input int unsigned n, input bit quad);
    for (int unsigned i = 0; i < n; i++) begin
      logic [31:0] w;
      int unsigned per;
      per = quad ? 8 : 32;
      w = m_words[bidx / per];
      if (quad) {spi_sdi3, spi_sdi2, spi_sdi1, spi_sdi0} = w[31 - 4 * (bidx % 8) -: 4];
      else spi_sdi0 = w[31 - (bidx % 32)];
      repeat (H) @(negedge HCLK);
      if (!quad && miso_chk) begin
        miso_acc = {miso_acc[30:0], spi_miso};
        mcnt++;
        if (mcnt == 32) begin
          if (exp_miso_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL miso_word: got %h expected a loaded TX word", miso_acc);
          end else begin
            check("miso_word", miso_acc, exp_miso_q.pop_front());
          end
          mcnt = 0;
        end
      end
      spi_clk = 1'b1;
      if (model_on && (bidx % per) == per - 1) begin
        if (rx_hold && exp_rx_q.size() != 0) exp_ovf = 1'b1;
        else exp_rx_q.push_back(w);
      end
      bidx++;
      repeat (H) @(negedge HCLK);
      spi_clk = 1'b0;
    end
  endtask

  task automatic cs_low();
    exp_miso_q.delete();
    mcnt = 0;
    bidx = 0;
    spi_csn = 1'b0;
    repeat (H) @(negedge HCLK);
  endtask

  task automatic cs_high(input bit quad);
    logic [31:0] mask;
    repeat (H) @(negedge HCLK);
    spi_csn = 1'b1;
    repeat (4 * H) @(negedge HCLK);
    if (!quad && miso_chk && mcnt != 0 && exp_miso_q.size() != 0) begin
      mask = (32'd1 << mcnt) - 32'd1;
      check("miso_partial", miso_acc & mask, exp_miso_q[0] >> (32 - mcnt));
    end
    exp_miso_q.delete();
    m_words.delete();
  endtask

  task automatic run_window(input int unsigned nbits, input bit quad);
    int unsigned per;
    per = quad ? 8 : 32;
    cs_low();
    send_bits(nbits, quad);
    cs_high(quad);
    exp_eot++;
    if (nbits % per != 0) exp_partial++;
    if (!quad) begin
      exp_loads += 1 + nbits / 32;
      if (!u_if.tx_valid_i) exp_und = 1'b1;
    end
  endtask

  task automatic end_checks();
    repeat (10) @(negedge HCLK);
    check("rx_pending", exp_rx_q.size(), 0);
    check("eot_count", eot_cnt, exp_eot);
    check("partial_count", partial_cnt, exp_partial);
    check("tx_loads", load_cnt, exp_loads);
    check("overflow_flag", rx_overflow_o, exp_ovf);
    check("underrun_flag", tx_underrun_o, exp_und);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    u_if.tx_valid_i = 1'b1;
    repeat (5) @(negedge HCLK);
    check("rst_miso", spi_miso, 0);
    check("rst_miso_oe", spi_miso_oe, 0);
    check("rst_rx_data", u_if.rx_data_o, 0);
    check("rst_rx_valid", u_if.rx_valid_o, 0);
    check("rst_tx_ready", u_if.tx_ready_o, 0);
    check("rst_eot", eot_o, 0);
    check("rst_partial", rx_partial_o, 0);
    check("rst_overflow", rx_overflow_o, 0);
    check("rst_underrun", tx_underrun_o, 0);
    HRESET = 1'b0;
    repeat (10) @(negedge HCLK);

    // Standard loopback with preloaded TX word.
    m_words = '{32'h1234_5678};
    run_window(32, 1'b0);
    end_checks();

`ifdef SPI_SLAVE_QUAD_EN
    qmode_i = 1'b1;
    oe_seen = 1'b0;
    m_words = '{32'hDEAD_BEEF};
    run_window(8, 1'b1);
    check("quad_oe", oe_seen, 0);
    end_checks();
    qmode_i = 1'b0;
`endif

    // Overflow with ready held low.
    rx_hold = 1'b1;
    m_words = '{32'h0000_0001, 32'h0000_0002};
    run_window(64, 1'b0);
    check("ovf_valid", u_if.rx_valid_o, 1);
    check("ovf_data", u_if.rx_data_o, 32'h1);
    check("ovf_flag", rx_overflow_o, exp_ovf);
    rx_hold = 1'b0;
    repeat (20) @(negedge HCLK);
    check("ovf_drained", u_if.rx_valid_o, 0);
    end_checks();

    // Partial word with TX underrun.
    u_if.tx_valid_i = 1'b0;
    m_words = '{$urandom};
    run_window(12, 1'b0);
    end_checks();
    u_if.tx_valid_i = 1'b1;

    // Reset in the middle of a word with csn held low.
    miso_chk = 1'b0;
    m_words = '{$urandom};
    cs_low();
    send_bits(10, 1'b0);
    exp_loads += 1;
    HRESET = 1'b1;
    @(negedge HCLK);
    HRESET = 1'b0;
    exp_ovf = 1'b0;
    exp_und = 1'b0;
    check("mid_rst_miso", spi_miso, 0);
    check("mid_rst_oe", spi_miso_oe, 0);
    check("mid_rst_valid", u_if.rx_valid_o, 0);
    check("mid_rst_ovf", rx_overflow_o, 0);
    check("mid_rst_und", tx_underrun_o, 0);
    model_on = 1'b0;
    send_bits(22, 1'b0);
    cs_high(1'b0);
    model_on = 1'b1;
    miso_chk = 1'b1;
    end_checks();
    m_words = '{32'hCAFE_F00D};
    run_window(32, 1'b0);
    end_checks();

    // Back-to-back words in one CS window.
    m_words = '{32'h0000_0001, 32'h8000_0000};
    run_window(64, 1'b0);
    end_checks();

    // Randomised windows: 1-2 words, optional trailing partial, random TX supply.
    for (int unsigned t = 0; t < 6; t++) begin
      int unsigned nw, nbits;
      nw = $urandom_range(1, 2);
      nbits = nw * 32 + (($urandom_range(0, 1) == 1) ? $urandom_range(1, 31) : 0);
      u_if.tx_valid_i = 1'($urandom_range(0, 1));
      for (int unsigned k = 0; k <= nw; k++) m_words.push_back($urandom);
      run_window(nbits, 1'b0);
      end_checks();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
